// File: rtl/model_ntm_vector_arithmetic_if.sv
// Element-stream bus between the NTM controller and the vector arithmetic unit.
// Handshake: the unit raises data_enable while it wants an operand pair; data_a_in /
// data_b_in are taken on any rising edge where their *_enable is high during that window.
// data_out is valid on cycles where data_out_enable is high. ready pulses once per
// completed vector. state_dbg mirrors the FSM state.
interface model_ntm_vector_arithmetic_if #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
);
    logic                    start;
    logic                    ready;
    logic [CONTROL_SIZE-1:0] operation;
    logic [CONTROL_SIZE-1:0] size_in;
    logic                    data_a_in_enable;
    logic                    data_b_in_enable;
    logic [DATA_SIZE-1:0]    data_a_in;
    logic [DATA_SIZE-1:0]    data_b_in;
    logic                    data_enable;
    logic                    data_out_enable;
    logic [DATA_SIZE-1:0]    data_out;
    logic [1:0]              state_dbg;

    modport master (
        output start, operation, size_in, data_a_in_enable, data_b_in_enable,
               data_a_in, data_b_in,
        input  ready, data_enable, data_out_enable, data_out, state_dbg
    );

    modport slave (
        input  start, operation, size_in, data_a_in_enable, data_b_in_enable,
               data_a_in, data_b_in,
        output ready, data_enable, data_out_enable, data_out, state_dbg
    );
endinterface

// File: rtl/model_ntm_vector_arithmetic.sv
// Streaming element-wise ADD/SUB/MUL/MAX over two vectors of runtime length.
// Define MODEL_NTM_SATURATE_EN to clamp ADD/SUB/MUL overflow instead of wrapping.
module model_ntm_vector_arithmetic #(
    parameter int DATA_SIZE     = 64,
    parameter int CONTROL_SIZE  = 4,
    parameter int FRACTION_SIZE = 32
) (
    input logic                        clk,
    input logic                        rst,
    model_ntm_vector_arithmetic_if.slave bus
);
    typedef enum logic [1:0] {
        STARTER_STATE,
        INPUT_STATE,
        OPERATION_STATE,
        ENDER_STATE
    } state_t;

    localparam logic [CONTROL_SIZE-1:0] OP_SUB = CONTROL_SIZE'(1);
    localparam logic [CONTROL_SIZE-1:0] OP_MUL = CONTROL_SIZE'(2);
    localparam logic [CONTROL_SIZE-1:0] OP_MAX = CONTROL_SIZE'(3);

    state_t                      state, state_next;
    logic [CONTROL_SIZE-1:0]     op_reg, size_reg, index;
    logic signed [DATA_SIZE-1:0] a_reg, b_reg;
    logic                        a_flag, b_flag;
    logic                        ready_q, data_enable_q, data_out_enable_q;
    logic [DATA_SIZE-1:0]        data_out_q;

    logic [2*DATA_SIZE-1:0]        prod;
    logic signed [2*DATA_SIZE-1:0] prod_shift;
    logic [DATA_SIZE-1:0]          add_res, sub_res, mul_res, max_res, result;

    always_comb begin
        prod       = {{DATA_SIZE{a_reg[DATA_SIZE-1]}}, a_reg} *
                     {{DATA_SIZE{b_reg[DATA_SIZE-1]}}, b_reg};
        prod_shift = $signed(prod) >>> FRACTION_SIZE;
        max_res    = (a_reg > b_reg) ? a_reg : b_reg;
    end

`ifdef MODEL_NTM_SATURATE_EN
    localparam logic [DATA_SIZE-1:0] POS_LIMIT = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] NEG_LIMIT = {1'b1, {(DATA_SIZE-1){1'b0}}};

    logic [DATA_SIZE:0]   sum_ext, diff_ext;
    logic [DATA_SIZE:0]   mul_top;

    always_comb begin
        sum_ext  = {a_reg[DATA_SIZE-1], a_reg} + {b_reg[DATA_SIZE-1], b_reg};
        diff_ext = {a_reg[DATA_SIZE-1], a_reg} - {b_reg[DATA_SIZE-1], b_reg};
        // Product fits only if every bit from the sign down to bit DATA_SIZE-1 agrees.
        mul_top  = prod_shift[2*DATA_SIZE-1:DATA_SIZE-1];
        add_res  = sum_ext[DATA_SIZE-1:0];
        sub_res  = diff_ext[DATA_SIZE-1:0];
        mul_res  = prod_shift[DATA_SIZE-1:0];
        if (sum_ext[DATA_SIZE] != sum_ext[DATA_SIZE-1])
            add_res = sum_ext[DATA_SIZE] ? NEG_LIMIT : POS_LIMIT;
        if (diff_ext[DATA_SIZE] != diff_ext[DATA_SIZE-1])
            sub_res = diff_ext[DATA_SIZE] ? NEG_LIMIT : POS_LIMIT;
        if (!(&mul_top) && (|mul_top))
            mul_res = mul_top[DATA_SIZE] ? NEG_LIMIT : POS_LIMIT;
    end
`else
    logic mul_hi_unused;

    assign add_res       = a_reg + b_reg;
    assign sub_res       = a_reg - b_reg;
    assign mul_res       = prod_shift[DATA_SIZE-1:0];
    assign mul_hi_unused = ^prod_shift[2*DATA_SIZE-1:DATA_SIZE];
`endif

    always_comb begin
        case (op_reg)
            OP_SUB:  result = sub_res;
            OP_MUL:  result = mul_res;
            OP_MAX:  result = max_res;
            default: result = add_res;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            // START landing in the READY cycle is deliberately dropped.
            STARTER_STATE:
                if (bus.start && !ready_q)
                    state_next = (bus.size_in == '0) ? ENDER_STATE : INPUT_STATE;
            INPUT_STATE:
                if ((a_flag || bus.data_a_in_enable) && (b_flag || bus.data_b_in_enable))
                    state_next = OPERATION_STATE;
            OPERATION_STATE:
                state_next = (index == size_reg - CONTROL_SIZE'(1)) ? ENDER_STATE : INPUT_STATE;
            ENDER_STATE:
                state_next = STARTER_STATE;
            default:
                state_next = STARTER_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= STARTER_STATE;
            op_reg            <= '0;
            size_reg          <= '0;
            index             <= '0;
            a_reg             <= '0;
            b_reg             <= '0;
            a_flag            <= 1'b0;
            b_flag            <= 1'b0;
            ready_q           <= 1'b0;
            data_enable_q     <= 1'b0;
            data_out_enable_q <= 1'b0;
            data_out_q        <= '0;
        end else begin
            state             <= state_next;
            ready_q           <= (state == ENDER_STATE);
            data_enable_q     <= (state_next == INPUT_STATE);
            data_out_enable_q <= (state == OPERATION_STATE);
            case (state)
                STARTER_STATE:
                    if (bus.start && !ready_q) begin
                        op_reg   <= bus.operation;
                        size_reg <= bus.size_in;
                    end
                INPUT_STATE: begin
                    if (bus.data_a_in_enable) begin
                        a_reg  <= bus.data_a_in;
                        a_flag <= 1'b1;
                    end
                    if (bus.data_b_in_enable) begin
                        b_reg  <= bus.data_b_in;
                        b_flag <= 1'b1;
                    end
                end
                OPERATION_STATE: begin
                    data_out_q <= result;
                    a_flag     <= 1'b0;
                    b_flag     <= 1'b0;
                    if (state_next == INPUT_STATE)
                        index <= index + CONTROL_SIZE'(1);
                end
                ENDER_STATE:
                    index <= '0;
                default: ;
            endcase
        end
    end

    assign bus.ready           = ready_q;
    assign bus.data_enable     = data_enable_q;
    assign bus.data_out_enable = data_out_enable_q;
    assign bus.data_out        = data_out_q;
    assign bus.state_dbg       = state;
endmodule
